// File: rtl/riscv_core_pkg.sv
// Shared core types for the RV32IM pipeline: exception/interrupt records,
// cause codes and the trap controller's state and kind enumerations.
package riscv_core_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] cause;
        logic [31:0] pc;
        logic [31:0] tval;
    } exception_info_t;

    typedef struct packed {
        logic meip;
        logic mtip;
        logic msip;
    } interrupt_info_t;

    localparam logic [31:0] EXC_CAUSE_INSN_MISALIGNED  = 32'd0;
    localparam logic [31:0] EXC_CAUSE_ILLEGAL_INSN     = 32'd2;
    localparam logic [31:0] EXC_CAUSE_BREAKPOINT       = 32'd3;
    localparam logic [31:0] EXC_CAUSE_LOAD_ACCESS      = 32'd5;
    localparam logic [31:0] EXC_CAUSE_ECALL_M          = 32'd11;
    localparam logic [31:0] EXC_CAUSE_IRQ_MSI          = 32'h8000_0003;
    localparam logic [31:0] EXC_CAUSE_IRQ_MTI          = 32'h8000_0007;
    localparam logic [31:0] EXC_CAUSE_IRQ_MEI          = 32'h8000_000B;
    localparam logic [31:0] EXC_CAUSE_NMI              = 32'h8000_0000;

    localparam logic [1:0]  MTVEC_MODE_DIRECT          = 2'b00;
    localparam logic [1:0]  MTVEC_MODE_VECTORED        = 2'b01;

    typedef enum logic [2:0] {
        TRAP_IDLE,
        TRAP_FLUSH,
        TRAP_CSR_WR,
        TRAP_MRET_WR,
        TRAP_REDIRECT
    } trap_state_e;

    typedef enum logic [1:0] {
        TRAP_EXC,
        TRAP_IRQ,
        TRAP_MRET,
        TRAP_NMI
    } trap_kind_e;

endpackage

// File: rtl/riscv_irq_prio.sv
// Combinational machine-interrupt qualifier and priority encoder.
// Order is MEI > MSI > MTI; nothing is taken without global enable and a
// valid instruction boundary to hang mepc on.
module riscv_irq_prio
    import riscv_core_pkg::*;
(
    input  interrupt_info_t i_pending,
    input  logic [2:0]      i_enable,
    input  logic            i_global_en,
    input  logic            i_pc_valid,
    output logic            o_valid,
    output logic [31:0]     o_cause
);

    // i_enable is packed as {mie[11], mie[7], mie[3]}
    always_comb begin
        o_valid = 1'b0;
        o_cause = '0;
        if (i_global_en && i_pc_valid) begin
            if (i_pending.meip && i_enable[2]) begin
                o_valid = 1'b1;
                o_cause = EXC_CAUSE_IRQ_MEI;
            end else if (i_pending.msip && i_enable[0]) begin
                o_valid = 1'b1;
                o_cause = EXC_CAUSE_IRQ_MSI;
            end else if (i_pending.mtip && i_enable[1]) begin
                o_valid = 1'b1;
                o_cause = EXC_CAUSE_IRQ_MTI;
            end
        end
    end

endmodule

// File: rtl/riscv_trap_ctrl.sv
// M-mode trap entry / MRET return sequencer.
// Optional feature macro: RISCV_TRAP_NMI_EN adds a level NMI input with a
// fixed handler address and an nmi_active block released by MRET.
module riscv_trap_ctrl
    import riscv_core_pkg::*;
#(
    parameter logic [31:0] NMI_VECTOR    = 32'h0000_0100,
    parameter int          VEC_IDX_WIDTH = 5
)
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  exception_info_t exc_i,
    input  interrupt_info_t irq_i,
    input  logic [31:0]     irq_pc_i,
    input  logic            irq_pc_valid_i,
    input  logic            mret_i,
    input  logic            mstatus_mie_i,
    input  logic [31:0]     mie_i,
    input  logic [31:0]     mtvec_i,
    input  logic [31:0]     mepc_i,
    input  logic            redirect_ready_i,
`ifdef RISCV_TRAP_NMI_EN
    input  logic            nmi_i,
`endif
    output logic            flush_o,
    output logic            stall_o,
    output logic            redirect_valid_o,
    output logic [31:0]     redirect_pc_o,
    output logic            csr_trap_we_o,
    output logic [31:0]     csr_mepc_o,
    output logic [31:0]     csr_mcause_o,
    output logic [31:0]     csr_mtval_o,
    output logic            csr_mret_o,
    output logic            busy_o
);

    trap_state_e r_state;
    trap_state_e w_next_state;
    trap_kind_e  r_kind;
    logic [31:0] r_cause;
    logic [31:0] r_epc;
    logic [31:0] r_tval;
    logic [31:0] r_target;

    logic        w_irq_valid;
    logic [31:0] w_irq_cause;
    logic        w_event;
    trap_kind_e  w_kind;
    logic [31:0] w_cause;
    logic [31:0] w_epc;
    logic [31:0] w_tval;
    logic [31:0] w_target;
    logic [31:0] w_base;
    logic [31:0] w_vec_off;
    logic        w_unused;

    riscv_irq_prio u_irq_prio (
        .i_pending   (irq_i),
        .i_enable    ({mie_i[11], mie_i[7], mie_i[3]}),
        .i_global_en (mstatus_mie_i),
        .i_pc_valid  (irq_pc_valid_i),
        .o_valid     (w_irq_valid),
        .o_cause     (w_irq_cause)
    );

`ifdef RISCV_TRAP_NMI_EN
    logic r_nmi_active;
    logic w_nmi_take;

    assign w_nmi_take = nmi_i & irq_pc_valid_i & ~r_nmi_active;
    assign w_unused   = ^{mie_i[31:12], mie_i[10:8], mie_i[6:4], mie_i[2:0]};

    // NMI is held off from the moment one is captured until its MRET strobe
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_nmi_active <= 1'b0;
        end else if (r_state == TRAP_IDLE && w_event && w_kind == TRAP_NMI) begin
            r_nmi_active <= 1'b1;
        end else if (r_state == TRAP_MRET_WR) begin
            r_nmi_active <= 1'b0;
        end
    end
`else
    assign w_unused = ^{mie_i[31:12], mie_i[10:8], mie_i[6:4], mie_i[2:0], NMI_VECTOR};
`endif

    // Pick the winning event of this cycle and compute what it would latch
    always_comb begin
        w_base    = {mtvec_i[31:2], 2'b00};
        w_vec_off = 32'(w_irq_cause[VEC_IDX_WIDTH-1:0]) << 2;
        w_event   = 1'b0;
        w_kind    = TRAP_EXC;
        w_cause   = '0;
        w_epc     = '0;
        w_tval    = '0;
        w_target  = w_base;
`ifdef RISCV_TRAP_NMI_EN
        if (w_nmi_take) begin
            w_event  = 1'b1;
            w_kind   = TRAP_NMI;
            w_cause  = EXC_CAUSE_NMI;
            w_epc    = irq_pc_i;
            w_target = NMI_VECTOR;
        end else
`endif
        if (exc_i.valid) begin
            w_event = 1'b1;
            w_kind  = TRAP_EXC;
            w_cause = exc_i.cause;
            w_epc   = exc_i.pc;
            w_tval  = exc_i.tval;
        end else if (w_irq_valid) begin
            w_event = 1'b1;
            w_kind  = TRAP_IRQ;
            w_cause = w_irq_cause;
            w_epc   = irq_pc_i;
            if (mtvec_i[1:0] == MTVEC_MODE_VECTORED) begin
                w_target = w_base + w_vec_off;
            end
        end else if (mret_i) begin
            w_event = 1'b1;
            w_kind  = TRAP_MRET;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= TRAP_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and per-state control strobes
    always_comb begin
        w_next_state     = r_state;
        flush_o          = 1'b0;
        csr_trap_we_o    = 1'b0;
        csr_mret_o       = 1'b0;
        redirect_valid_o = 1'b0;
        busy_o           = (r_state != TRAP_IDLE);
        stall_o          = (r_state != TRAP_IDLE);
        case (r_state)
            TRAP_IDLE: begin
                if (w_event) begin
                    w_next_state = TRAP_FLUSH;
                end
            end
            TRAP_FLUSH: begin
                flush_o      = 1'b1;
                w_next_state = (r_kind == TRAP_MRET) ? TRAP_MRET_WR : TRAP_CSR_WR;
            end
            TRAP_CSR_WR: begin
                csr_trap_we_o = 1'b1;
                w_next_state  = TRAP_REDIRECT;
            end
            TRAP_MRET_WR: begin
                csr_mret_o   = 1'b1;
                w_next_state = TRAP_REDIRECT;
            end
            TRAP_REDIRECT: begin
                redirect_valid_o = 1'b1;
                if (redirect_ready_i) begin
                    w_next_state = TRAP_IDLE;
                end
            end
            default: begin
                w_next_state = TRAP_IDLE;
            end
        endcase
    end

    // Capture the event record in IDLE; an MRET picks up mepc as it strobes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_kind   <= TRAP_EXC;
            r_cause  <= '0;
            r_epc    <= '0;
            r_tval   <= '0;
            r_target <= '0;
        end else if (r_state == TRAP_IDLE && w_event) begin
            r_kind   <= w_kind;
            r_cause  <= w_cause;
            r_epc    <= w_epc;
            r_tval   <= w_tval;
            r_target <= w_target;
        end else if (r_state == TRAP_MRET_WR) begin
            r_target <= mepc_i;
        end
    end

    assign csr_mepc_o    = r_epc;
    assign csr_mcause_o  = r_cause;
    assign csr_mtval_o   = r_tval;
    assign redirect_pc_o = r_target;

endmodule
